pipe_lane_ctrl: RTL and testbench
=================================

# pipe_lane_ctrl

Multi-lane PIPE MAC-side control block sitting between the LTSSM and the PHY PIPE interface. It generalises single-lane PIPE control to `LANES` lanes with a per-lane enable mask, and adds three behaviours:
- a PowerDown change handshake that waits for PhyStatus on every enabled lane;
- a receiver-detect sequencer that reports a per-lane result vector;
- timeout supervision for both handshakes.

## Interface
Parameters:
- `LANES`, 4, number of PIPE lanes.
- `DETECT_TIMEOUT`, 1024, pclk cycles allowed for a receiver-detect handshake.
- `PD_TIMEOUT`, 256, pclk cycles allowed for a PowerDown handshake.

Ports:
- `pclk`  in  1  PIPE clock; single clock domain.
- `reset`  in  1  reset; synchronous, active-high.
- `substate`  in  5  LTSSM substate code (DetectQuiet=0, DetectActive=1, others ≥2).
- `pd_target`  in  4  PowerDown requested by the LTSSM when substate ≥2.
- `lane_mask`  in  LANES  1 = lane enabled; sampled only in ST_IDLE.
- `elec_idle_req`  in  1  force electrical idle on all lanes.
- `detect_req`  in  1  level request for receiver detection.
- `PhyStatus`  in  LANES  per-lane PHY completion strobe.
- `RxStatus`  in  3*LANES  per-lane status; lane i at [3i+2:3i].
- `RxStandbyRequest`  in  LANES  per-lane standby request.
- `TxDetectRx_Loopback`  out  1  detect command, common to all lanes.
- `PowerDown`  out  4  common PowerDown encoding (P0=0, P0s=1, P1=2, P2=3).
- `TxElecIdle`  out  LANES  per-lane electrical idle.
- `RxStandby`  out  LANES  per-lane RX standby.
- `detect_done`  out  1  one-cycle pulse when a detect sequence ends.
- `detect_lanes`  out  LANES  per-lane receiver-present result; held until the next detect starts.
- `pd_done`  out  1  one-cycle pulse when a PowerDown change completes.
- `timeout_err`  out  1  one-cycle pulse when either handshake times out.

## Operation
- All outputs are registered.
- Effective target: `tgt` = 2 when substate ≤1, otherwise `pd_target`.
- FSM states: ST_IDLE, ST_PD_WAIT, ST_DETECT.
- ST_IDLE, checked in priority order:
  - If `tgt` ≠ PowerDown: load PowerDown←`tgt`, latch `mask_q`←`lane_mask`, clear the `seen` vector, clear the timer, and go to ST_PD_WAIT.
  - Else if `detect_req` and PowerDown==2: set TxDetectRx_Loopback=1, latch `mask_q`, clear `seen` and `detect_lanes`, clear the timer, and go to ST_DETECT.
- ST_PD_WAIT:
  - Set `seen[i]` on PhyStatus[i] for every lane in `mask_q`.
  - When all lanes in `mask_q` are seen (checked with the current-cycle PhyStatus included): pulse pd_done and return to ST_IDLE.
  - On timer == PD_TIMEOUT−1: pulse timeout_err and return to ST_IDLE. PowerDown keeps the new value.
  - Changes to `tgt` are ignored until ST_IDLE.
- ST_DETECT:
  - On PhyStatus[i] for a lane in `mask_q` that is not yet seen: set `seen[i]` and set `detect_lanes[i]`←(RxStatus[i]==3'b011).
  - When all lanes are seen: TxDetectRx_Loopback←0, pulse detect_done, return to ST_IDLE.
  - On timeout: TxDetectRx_Loopback←0, pulse detect_done and timeout_err. Lanes that never responded read 0.
- A `detect_req` raised during ST_PD_WAIT stays pending because it is a level. It is serviced from ST_IDLE only if PowerDown==2.
- A `detect_req` still high after detect_done starts a new sequence one cycle later. Upstream deasserts it on detect_done.
- TxElecIdle[i] = 1 when any of these hold: elec_idle_req, substate ≤1, lane_mask[i]==0. Otherwise 0. Updated every cycle in every state.
- RxStandby[i] = RxStandbyRequest[i] for enabled lanes and 1 for masked lanes, registered.
- An empty `mask_q` completes either handshake in the cycle after entry.
- PhyStatus on masked lanes, or in ST_IDLE, is ignored.

## Timing
- Reset values: PowerDown=2, TxElecIdle all 1, TxDetectRx_Loopback=0, RxStandby all 0, detect_lanes=0, detect_done=pd_done=timeout_err=0, FSM=ST_IDLE, timer=0.
- Reset mid-handshake abandons it immediately, with no done or error pulse.
- Latency:
  - `tgt` change → PowerDown update: 1 cycle.
  - Last PhyStatus → pd_done/detect_done: 1 cycle.
  - TxDetectRx_Loopback falls in the same cycle as detect_done.
- Timer width is clog2(max(DETECT_TIMEOUT, PD_TIMEOUT)+1). It resets on state entry and saturates.
- Simultaneous PhyStatus on several lanes in one cycle is accepted for all of them.
- Completion and timeout in the same cycle: completion wins and timeout_err does not pulse.

## Structure
- Shared package `pipe_pkg`:
  - substate codes: DetectQuiet, DetectActive, … L0, Idle;
  - PowerDown encodings: PD_P0, PD_P0S, PD_P1, PD_P2;
  - RxStatus code RXSTAT_RX_PRESENT=3'b011;
  - FSM state enum.
- One sub-module, `pipe_lane_tracker`, one instance per lane: holds `seen[i]` and `detect_lanes[i]`, and produces TxElecIdle[i] and RxStandby[i]. The top level keeps the FSM, the timer and the all-seen reduction.

## Test plan
- Reset, then substate=2 and pd_target=0: PowerDown 2→0 after 1 cycle. PhyStatus on lanes 0–3 in cycles 3,5,5,7 → pd_done one cycle after cycle 7; TxElecIdle=4'b0000.
- substate=1 with PowerDown=2, detect_req=1, lane_mask=4'b1111: PhyStatus on all four lanes with RxStatus=3,3,0,3 → detect_lanes=4'b1011, detect_done pulse, TxDetectRx_Loopback 1→0.
- lane_mask=4'b0011 and lane 1 never answers the detect: after DETECT_TIMEOUT cycles, detect_done and timeout_err pulse together, detect_lanes[1]=0, TxElecIdle[3:2]=2'b11.
- detect_req raised while in ST_PD_WAIT toward P0: no detect starts; PowerDown stays 0 and TxDetectRx_Loopback stays 0.
- Reset asserted 4 cycles into ST_DETECT: the next cycle shows all reset values and no done pulse.
- RxStandbyRequest=4'b0101 with lane_mask=4'b0111: RxStandby=4'b1101 one cycle later.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared LTSSM substate codes, PowerDown encodings, RxStatus codes and FSM states.
package pipe_pkg;
    typedef enum logic [4:0] {
        SS_DETECT_QUIET  = 5'd0,
        SS_DETECT_ACTIVE = 5'd1,
        SS_POLLING       = 5'd2,
        SS_CONFIG        = 5'd3,
        SS_L0            = 5'd4,
        SS_IDLE          = 5'd5
    } substate_e;

    typedef enum logic [3:0] {
        PD_P0  = 4'd0,
        PD_P0S = 4'd1,
        PD_P1  = 4'd2,
        PD_P2  = 4'd3
    } pd_e;

    localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PD_WAIT,
        ST_DETECT
    } state_e;
endpackage

// File: rtl/pipe_lane_ctrl_if.sv
// pipe_lane_ctrl_if: LTSSM/PHY-facing PIPE control signals; slave is the controller.
interface pipe_lane_ctrl_if #(parameter int LANES = 4);
    logic [4:0]         substate;
    logic [3:0]         pd_target;
    logic [LANES-1:0]   lane_mask;
    logic               elec_idle_req;
    logic               detect_req;
    logic [LANES-1:0]   PhyStatus;
    logic [3*LANES-1:0] RxStatus;
    logic [LANES-1:0]   RxStandbyRequest;
    logic               TxDetectRx_Loopback;
    logic [3:0]         PowerDown;
    logic [LANES-1:0]   TxElecIdle;
    logic [LANES-1:0]   RxStandby;
    logic               detect_done;
    logic [LANES-1:0]   detect_lanes;
    logic               pd_done;
    logic               timeout_err;

    modport master (
        output substate, pd_target, lane_mask, elec_idle_req, detect_req, PhyStatus, RxStatus, RxStandbyRequest,
        input  TxDetectRx_Loopback, PowerDown, TxElecIdle, RxStandby, detect_done, detect_lanes, pd_done, timeout_err
    );
    modport slave (
        input  substate, pd_target, lane_mask, elec_idle_req, detect_req, PhyStatus, RxStatus, RxStandbyRequest,
        output TxDetectRx_Loopback, PowerDown, TxElecIdle, RxStandby, detect_done, detect_lanes, pd_done, timeout_err
    );
endinterface

// File: rtl/pipe_lane_tracker.sv
// pipe_lane_tracker: per-lane handshake seen flag, detect result, TxElecIdle and RxStandby.
module pipe_lane_tracker
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_seen_i,
    input  logic       clr_det_i,
    input  logic       set_pd_i,
    input  logic       set_det_i,
    input  logic       en_q_i,
    input  logic       en_i,
    input  logic       phy_i,
    input  logic [2:0] rx_status_i,
    input  logic       standby_req_i,
    input  logic       force_idle_i,
    output logic       seen_o,
    output logic       present_o,
    output logic       tx_elec_idle_o,
    output logic       rx_standby_o
);
    logic seen_q, seen_d, present_q, present_d, ei_q, ei_d, sb_q, sb_d, hit;

    assign hit = phy_i & en_q_i;

    always_comb begin
        seen_d    = clr_seen_i ? 1'b0 : (hit & (set_pd_i | set_det_i)) ? 1'b1 : seen_q;
        // only the first response of a lane counts toward its detect result
        present_d = clr_det_i ? 1'b0 : (hit & set_det_i & ~seen_q) ? (rx_status_i == RXSTAT_RX_PRESENT) : present_q;
        ei_d      = force_idle_i | ~en_i;
        sb_d      = ~en_i | standby_req_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q    <= 1'b0;
            present_q <= 1'b0;
            ei_q      <= 1'b1;
            sb_q      <= 1'b0;
        end else begin
            seen_q    <= seen_d;
            present_q <= present_d;
            ei_q      <= ei_d;
            sb_q      <= sb_d;
        end
    end

    assign seen_o         = seen_q;
    assign present_o      = present_q;
    assign tx_elec_idle_o = ei_q;
    assign rx_standby_o   = sb_q;
endmodule

// File: rtl/pipe_lane_ctrl.sv
// pipe_lane_ctrl: multi-lane PIPE control with PowerDown and receiver-detect handshakes
// supervised by a shared saturating timer.
module pipe_lane_ctrl
    import pipe_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int DETECT_TIMEOUT = 1024,
    parameter int PD_TIMEOUT     = 256
) (
    input  logic pclk,
    input  logic reset,
    pipe_lane_ctrl_if.slave pipe
);
    localparam int TMAX = (DETECT_TIMEOUT > PD_TIMEOUT) ? DETECT_TIMEOUT : PD_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_e           state_q, state_d;
    logic [3:0]       pd_q, pd_d, tgt;
    logic [LANES-1:0] mask_q, mask_d, seen, present, tx_ei, rx_sb;
    logic [TW-1:0]    timer_q, timer_d;
    logic             txdet_q, txdet_d, pd_done_q, pd_done_d, det_done_q, det_done_d, to_q, to_d;
    logic             force_idle, pd_start, det_start, in_pd, in_det, all_seen, t_pd, t_det;

    assign force_idle = pipe.elec_idle_req | (pipe.substate <= 5'd1);
    assign tgt        = (pipe.substate <= 5'd1) ? PD_P1 : pipe.pd_target;
    assign pd_start   = (state_q == ST_IDLE) && (tgt != pd_q);
    assign det_start  = (state_q == ST_IDLE) && !pd_start && pipe.detect_req && (pd_q == PD_P1);
    assign in_pd      = state_q == ST_PD_WAIT;
    assign in_det     = state_q == ST_DETECT;
    // current-cycle PhyStatus counts, so completion lands one cycle after the last strobe
    assign all_seen   = &(seen | (pipe.PhyStatus & mask_q) | ~mask_q);
    assign t_pd       = timer_q == TW'(PD_TIMEOUT - 1);
    assign t_det      = timer_q == TW'(DETECT_TIMEOUT - 1);

    always_ff @(posedge pclk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = pd_start ? ST_PD_WAIT : det_start ? ST_DETECT : ST_IDLE;
            ST_PD_WAIT: state_d = (all_seen || t_pd) ? ST_IDLE : ST_PD_WAIT;
            ST_DETECT:  state_d = (all_seen || t_det) ? ST_IDLE : ST_DETECT;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pd_d       = pd_start ? tgt : pd_q;
        mask_d     = (pd_start || det_start) ? pipe.lane_mask : mask_q;
        timer_d    = (pd_start || det_start) ? '0 : (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;
        pd_done_d  = in_pd && all_seen;
        det_done_d = in_det && (all_seen || t_det);
        to_d       = !all_seen && ((in_pd && t_pd) || (in_det && t_det));
        txdet_d    = det_start ? 1'b1 : det_done_d ? 1'b0 : txdet_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            pd_q       <= PD_P1;
            mask_q     <= '0;
            timer_q    <= '0;
            txdet_q    <= 1'b0;
            pd_done_q  <= 1'b0;
            det_done_q <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            pd_q       <= pd_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            txdet_q    <= txdet_d;
            pd_done_q  <= pd_done_d;
            det_done_q <= det_done_d;
            to_q       <= to_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_lane_tracker u_trk (
            .clk            (pclk),
            .rst            (reset),
            .clr_seen_i     (pd_start | det_start),
            .clr_det_i      (det_start),
            .set_pd_i       (in_pd),
            .set_det_i      (in_det),
            .en_q_i         (mask_q[i]),
            .en_i           (pipe.lane_mask[i]),
            .phy_i          (pipe.PhyStatus[i]),
            .rx_status_i    (pipe.RxStatus[3*i +: 3]),
            .standby_req_i  (pipe.RxStandbyRequest[i]),
            .force_idle_i   (force_idle),
            .seen_o         (seen[i]),
            .present_o      (present[i]),
            .tx_elec_idle_o (tx_ei[i]),
            .rx_standby_o   (rx_sb[i])
        );
    end

    assign pipe.TxDetectRx_Loopback = txdet_q;
    assign pipe.PowerDown           = pd_q;
    assign pipe.TxElecIdle          = tx_ei;
    assign pipe.RxStandby           = rx_sb;
    assign pipe.detect_done         = det_done_q;
    assign pipe.detect_lanes        = present;
    assign pipe.pd_done             = pd_done_q;
    assign pipe.timeout_err         = to_q;
endmodule

// File: tb/tb_pipe_lane_ctrl.sv
// tb_pipe_lane_ctrl: directed stimulus; expected done/timeout events are queued with their
// due cycle and a negedge monitor matches them against every pulse the DUT emits.
module tb_pipe_lane_ctrl;
    import pipe_pkg::*;

    localparam int L  = 4;
    localparam int DT = 1024;
    localparam int PT = 256;

    typedef struct {
        int         cyc;
        logic       pd;
        logic       det;
        logic       to;
        logic [L-1:0] lanes;
    } exp_t;

    logic pclk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   s;
    exp_t q[$];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    pipe_lane_ctrl_if #(.LANES(L)) pipe ();

    pipe_lane_ctrl #(.LANES(L), .DETECT_TIMEOUT(DT), .PD_TIMEOUT(PT)) dut (
        .pclk  (pclk),
        .reset (reset),
        .pipe  (pipe)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic expect_ev(input int at, input logic pd, input logic det, input logic to, input logic [L-1:0] lanes);
        exp_t e;
        e.cyc = at; e.pd = pd; e.det = det; e.to = to; e.lanes = lanes;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_PowerDown"}, pipe.PowerDown, 2);
        chk({n, "_TxElecIdle"}, pipe.TxElecIdle, 4'hF);
        chk({n, "_Loopback"}, pipe.TxDetectRx_Loopback, 0);
        chk({n, "_RxStandby"}, pipe.RxStandby, 0);
        chk({n, "_detect_lanes"}, pipe.detect_lanes, 0);
        chk({n, "_pulses"}, {pipe.pd_done, pipe.detect_done, pipe.timeout_err}, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!reset && (pipe.pd_done || pipe.detect_done || pipe.timeout_err)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got pd=%b det=%b to=%b at cycle %0d want no event",
                             pipe.pd_done, pipe.detect_done, pipe.timeout_err, cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || pipe.pd_done !== e.pd || pipe.detect_done !== e.det ||
                        pipe.timeout_err !== e.to || (e.det && pipe.detect_lanes !== e.lanes)) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d pd=%b det=%b to=%b lanes=%b want cyc=%0d pd=%b det=%b to=%b lanes=%b",
                                 cyc, pipe.pd_done, pipe.detect_done, pipe.timeout_err, pipe.detect_lanes,
                                 e.cyc, e.pd, e.det, e.to, e.lanes);
                    end
                    if (pipe.detect_done) chk("loopback_at_done", pipe.TxDetectRx_Loopback, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        pipe.substate = 5'd0;
        pipe.pd_target = 4'd0;
        pipe.lane_mask = 4'hF;
        pipe.elec_idle_req = 1'b0;
        pipe.detect_req = 1'b0;
        pipe.PhyStatus = '0;
        pipe.RxStatus = '0;
        pipe.RxStandbyRequest = '0;
        reset = 1'b1;
        tick(3);
        chk_reset_vals("reset");
        reset = 1'b0;
        tick(2);

        // PowerDown P1 -> P0 with staggered PhyStatus
        pipe.substate = 5'd2;
        pipe.pd_target = 4'd0;
        chk("pd_before_edge", pipe.PowerDown, 2);
        tick();
        chk("pd_to_p0", pipe.PowerDown, 0);
        chk("txei_active", pipe.TxElecIdle, 4'b0000);
        pipe.PhyStatus = 4'b0001;
        tick();
        pipe.PhyStatus = 4'b0000;
        tick();
        pipe.PhyStatus = 4'b0110;
        tick();
        pipe.PhyStatus = 4'b0000;
        tick();
        pipe.PhyStatus = 4'b1000;
        expect_ev(cyc + 1, 1, 0, 0, '0);
        tick();
        pipe.PhyStatus = 4'b0000;
        drain(2000);

        // back to P1 for detect
        pipe.substate = 5'd1;
        tick();
        chk("pd_to_p1", pipe.PowerDown, 2);
        pipe.PhyStatus = 4'hF;
        expect_ev(cyc + 1, 1, 0, 0, '0);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);

        // detect on all lanes, lane 2 absent
        pipe.detect_req = 1'b1;
        tick();
        chk("det_loopback_up", pipe.TxDetectRx_Loopback, 1);
        pipe.detect_req = 1'b0;
        pipe.PhyStatus = 4'hF;
        pipe.RxStatus = {3'd3, 3'd0, 3'd3, 3'd3};
        expect_ev(cyc + 1, 0, 1, 0, 4'b1011);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);
        chk("det_lanes_held", pipe.detect_lanes, 4'b1011);

        // detect timeout: lane 1 never answers
        pipe.lane_mask = 4'b0011;
        pipe.detect_req = 1'b1;
        tick();
        s = cyc;
        chk("det2_loopback_up", pipe.TxDetectRx_Loopback, 1);
        chk("det2_lanes_cleared", pipe.detect_lanes, 0);
        pipe.detect_req = 1'b0;
        pipe.PhyStatus = 4'b0001;
        expect_ev(s + DT, 0, 1, 1, 4'b0001);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);
        chk("det2_txei_hi", pipe.TxElecIdle[3:2], 2'b11);

        // standby and electrical idle follow lane_mask
        pipe.substate = 5'd2;
        pipe.pd_target = 4'd2;
        pipe.lane_mask = 4'b0111;
        pipe.RxStandbyRequest = 4'b0101;
        tick();
        chk("rx_standby", pipe.RxStandby, 4'b1101);
        chk("txei_mask", pipe.TxElecIdle, 4'b1000);
        pipe.elec_idle_req = 1'b1;
        tick();
        chk("txei_forced", pipe.TxElecIdle, 4'hF);
        pipe.elec_idle_req = 1'b0;
        pipe.RxStandbyRequest = 4'b0000;

        // detect_req during a PowerDown change toward P0 must not start a detect
        pipe.lane_mask = 4'hF;
        pipe.pd_target = 4'd0;
        tick();
        chk("pd4_to_p0", pipe.PowerDown, 0);
        pipe.detect_req = 1'b1;
        tick(2);
        pipe.PhyStatus = 4'hF;
        expect_ev(cyc + 1, 1, 0, 0, '0);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pending_no_detect", pipe.TxDetectRx_Loopback, 0);
            chk("pending_pd_p0", pipe.PowerDown, 0);
        end
        pipe.detect_req = 1'b0;

        // completion on the timeout cycle: completion wins
        pipe.pd_target = 4'd3;
        tick();
        s = cyc;
        chk("pd_to_p2", pipe.PowerDown, 3);
        tick(PT - 1);
        pipe.PhyStatus = 4'hF;
        expect_ev(cyc + 1, 1, 0, 0, '0);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);

        // PowerDown timeout, masked-lane strobes ignored
        pipe.pd_target = 4'd0;
        pipe.lane_mask = 4'b0011;
        tick();
        s = cyc;
        pipe.PhyStatus = 4'b1101;
        expect_ev(s + PT, 0, 0, 1, '0);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);
        chk("pd_kept_after_timeout", pipe.PowerDown, 0);

        // empty mask completes in the cycle after entry
        pipe.lane_mask = 4'b0000;
        pipe.pd_target = 4'd1;
        tick();
        s = cyc;
        expect_ev(s + 1, 1, 0, 0, '0);
        drain(2000);

        // reset 4 cycles into a detect
        pipe.substate = 5'd1;
        pipe.lane_mask = 4'hF;
        pipe.RxStandbyRequest = 4'hF;
        tick();
        pipe.PhyStatus = 4'hF;
        expect_ev(cyc + 1, 1, 0, 0, '0);
        tick();
        pipe.PhyStatus = 4'h0;
        drain(2000);
        pipe.detect_req = 1'b1;
        tick();
        chk("det3_loopback_up", pipe.TxDetectRx_Loopback, 1);
        chk("det3_standby_before_reset", pipe.RxStandby, 4'hF);
        tick(3);
        reset = 1'b1;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        pipe.detect_req = 1'b0;
        pipe.RxStandbyRequest = 4'h0;
        tick(3);
        chk("no_events_after_reset", q.size(), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
